dot_product_sequencer: RTL and testbench

Control block that sequences one dot-product operation over the operand memories and the result memory of the dot-product system. On `start` it streams `VECTOR_WIDTH` element pairs from the A/B operand memories, multiply-accumulates them internally, writes the result to the next free result-memory slot, and pulses `done`. It sits between the system-level start/busy/done handshake and the memory datapath, replacing ad-hoc sequencing in the top level.

---
 rtl/dot_product_pkg.sv | 24 ++
 rtl/dp_mac_accumulator.sv | 38 +++
 rtl/dot_product_sequencer.sv | 175 +++++++++++++++++
 tb/tb_dot_product_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/dot_product_pkg.sv
// Shared definitions for the dot-product sequencer: FSM state codes (exported
// on the stage output) and width-derivation helpers.
package dot_product_pkg;

  localparam int STAGE_WIDTH = 3;

  typedef enum logic [STAGE_WIDTH-1:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_DRAIN = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } dp_state_e;

  // Accumulator width that can never overflow for vector_width full-scale products.
  function automatic int calc_result_width(input int data_width, input int vector_width);
    return 2 * data_width + $clog2(vector_width);
  endfunction

  function automatic int calc_index_width(input int vector_width);
    return (vector_width > 1) ? $clog2(vector_width) : 1;
  endfunction

endpackage

// File: rtl/dp_mac_accumulator.sv
// Unsigned multiply-accumulate register; clear has priority over a valid
// element pair arriving in the same cycle.
module dp_mac_accumulator
  import dot_product_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int RESULT_WIDTH = 18
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    valid,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic [RESULT_WIDTH-1:0] acc
);

  logic [2*DATA_WIDTH-1:0] product_s;
  logic [RESULT_WIDTH-1:0] acc_r;

  assign product_s = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};

  // Accumulator register
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r <= '0;
    end else if (clear) begin
      acc_r <= '0;
    end else if (valid) begin
      acc_r <= acc_r + RESULT_WIDTH'(product_s);
    end else begin
      acc_r <= acc_r;
    end
  end

  assign acc = acc_r;

endmodule

// File: rtl/dot_product_sequencer.sv
// Sequences one dot product: streams operand pairs from the A/B memories,
// accumulates them, writes the result to the next result-memory slot, pulses done.
module dot_product_sequencer
  import dot_product_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int VECTOR_WIDTH    = 4,
  parameter int ADDR_WIDTH      = 5,
  parameter int RESULT_WIDTH    = calc_result_width(DATA_WIDTH, VECTOR_WIDTH),
  parameter int MEM3_ADDR_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       clear_results,
  input  logic [ADDR_WIDTH-1:0]      base_addr,
  output logic                       busy,
  output logic                       done,
  output logic [2:0]                 stage,
  output logic                       mem_rd_en,
  output logic [ADDR_WIDTH-1:0]      mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]      mem_a_data,
  input  logic [DATA_WIDTH-1:0]      mem_b_data,
  output logic                       res_wr_en,
  output logic [MEM3_ADDR_WIDTH-1:0] res_wr_addr,
  output logic [DATA_WIDTH-1:0]      res_wr_data,
  output logic [RESULT_WIDTH-1:0]    dot_result,
  output logic [MEM3_ADDR_WIDTH:0]   result_count,
  output logic                       overflow
);

  localparam int IDX_WIDTH = calc_index_width(VECTOR_WIDTH);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(VECTOR_WIDTH - 1);
  localparam logic [MEM3_ADDR_WIDTH:0] FULL_COUNT = {1'b1, {MEM3_ADDR_WIDTH{1'b0}}};

  dp_state_e                  state_r;
  dp_state_e                  next_state_s;
  logic                       accept_s;
  logic                       clear_res_s;
  logic                       fetch_s;
  logic                       write_s;
  logic [ADDR_WIDTH-1:0]      base_r;
  logic [IDX_WIDTH-1:0]       idx_r;
  logic                       rd_valid_r;
  logic [MEM3_ADDR_WIDTH-1:0] ptr_r;
  logic [MEM3_ADDR_WIDTH:0]   count_r;
  logic                       overflow_r;
  logic [RESULT_WIDTH-1:0]    dot_result_r;
  logic [RESULT_WIDTH-1:0]    acc_s;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and control decode; start/clear are only looked at in IDLE
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    clear_res_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (clear_results) begin
          clear_res_s = 1'b1;
        end else begin
          clear_res_s = 1'b0;
        end
        if (start) begin
          accept_s     = 1'b1;
          next_state_s = ST_FETCH;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (idx_r == LAST_IDX) begin
          next_state_s = ST_DRAIN;
        end else begin
          next_state_s = ST_FETCH;
        end
      end
      ST_DRAIN: next_state_s = ST_WRITE;
      ST_WRITE: next_state_s = ST_DONE;
      ST_DONE:  next_state_s = ST_IDLE;
      default:  next_state_s = ST_IDLE;
    endcase
  end

  assign fetch_s = (state_r == ST_FETCH);
  assign write_s = (state_r == ST_WRITE);

  // Operand base latch and element index
  always_ff @(posedge clk) begin
    if (rst) begin
      base_r <= '0;
      idx_r  <= '0;
    end else if (accept_s) begin
      base_r <= base_addr;
      idx_r  <= '0;
    end else if (fetch_s) begin
      idx_r  <= idx_r + IDX_WIDTH'(1'b1);
    end else begin
      idx_r  <= idx_r;
    end
  end

  // Read data arrives one cycle after the strobe, so qualify the MAC with a delayed copy
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= fetch_s;
    end
  end

  dp_mac_accumulator #(
    .DATA_WIDTH   (DATA_WIDTH),
    .RESULT_WIDTH (RESULT_WIDTH)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clear (accept_s),
    .valid (rd_valid_r),
    .a     (mem_a_data),
    .b     (mem_b_data),
    .acc   (acc_s)
  );

  // Result pointer, saturating count and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r        <= '0;
      count_r      <= '0;
      overflow_r   <= 1'b0;
      dot_result_r <= '0;
    end else if (clear_res_s) begin
      ptr_r        <= '0;
      count_r      <= '0;
      overflow_r   <= 1'b0;
      dot_result_r <= dot_result_r;
    end else if (write_s) begin
      ptr_r        <= ptr_r + MEM3_ADDR_WIDTH'(1'b1);
      dot_result_r <= acc_s;
      if (count_r == FULL_COUNT) begin
        count_r    <= count_r;
        overflow_r <= 1'b1;
      end else begin
        count_r    <= count_r + (MEM3_ADDR_WIDTH + 1)'(1'b1);
        overflow_r <= overflow_r;
      end
    end else begin
      ptr_r        <= ptr_r;
      count_r      <= count_r;
      overflow_r   <= overflow_r;
      dot_result_r <= dot_result_r;
    end
  end

  assign busy         = (state_r == ST_FETCH) || (state_r == ST_DRAIN) || (state_r == ST_WRITE);
  assign done         = (state_r == ST_DONE);
  assign stage        = state_r;
  assign mem_rd_en    = fetch_s;
  assign mem_rd_addr  = fetch_s ? (base_r + ADDR_WIDTH'(idx_r)) : '0;
  assign res_wr_en    = write_s;
  assign res_wr_addr  = write_s ? ptr_r : '0;
  assign res_wr_data  = write_s ? acc_s[DATA_WIDTH-1:0] : '0;
  assign dot_result   = dot_result_r;
  assign result_count = count_r;
  assign overflow     = overflow_r;

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Self-checking bench: operand memories modelled as arrays; expected sums,
// slots, counts and overflow derived from the number of writes since clear.
module tb_dot_product_sequencer;

  localparam int DW = 8;
  localparam int VW = 4;
  localparam int AW = 5;
  localparam int MW = 4;
  localparam int RW = 2 * DW + $clog2(VW);
  localparam int DEPTH = 1 << AW;
  localparam int SLOTS = 1 << MW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start;
  logic          clear_results;
  logic [AW-1:0] base_addr;
  logic          busy;
  logic          done;
  logic [2:0]    stage;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_a_data = '0;
  logic [DW-1:0] mem_b_data = '0;
  logic          res_wr_en;
  logic [MW-1:0] res_wr_addr;
  logic [DW-1:0] res_wr_data;
  logic [RW-1:0] dot_result;
  logic [MW:0]   result_count;
  logic          overflow;

  logic [DW-1:0] mem_a [0:DEPTH-1];
  logic [DW-1:0] mem_b [0:DEPTH-1];

  int n_compared   = 0;
  int n_mismatched = 0;
  int n_writes     = 0;

  dot_product_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .clear_results (clear_results),
    .base_addr     (base_addr),
    .busy          (busy),
    .done          (done),
    .stage         (stage),
    .mem_rd_en     (mem_rd_en),
    .mem_rd_addr   (mem_rd_addr),
    .mem_a_data    (mem_a_data),
    .mem_b_data    (mem_b_data),
    .res_wr_en     (res_wr_en),
    .res_wr_addr   (res_wr_addr),
    .res_wr_data   (res_wr_data),
    .dot_result    (dot_result),
    .result_count  (result_count),
    .overflow      (overflow)
  );

  // Synchronous-read operand memories
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_a_data <= mem_a[mem_rd_addr];
      mem_b_data <= mem_b[mem_rd_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_stage"}, stage, 0);
    check_eq({tag, "_rd_en"}, mem_rd_en, 0);
    check_eq({tag, "_rd_addr"}, mem_rd_addr, 0);
    check_eq({tag, "_wr_en"}, res_wr_en, 0);
    check_eq({tag, "_wr_addr"}, res_wr_addr, 0);
    check_eq({tag, "_wr_data"}, res_wr_data, 0);
    check_eq({tag, "_dot"}, dot_result, 0);
    check_eq({tag, "_count"}, result_count, 0);
    check_eq({tag, "_ovf"}, overflow, 0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = DW'($urandom);
      mem_b[i] = DW'($urandom);
    end
  endtask

  // One operation, checked cycle by cycle; poke drives start/clear during FETCH,
  // abort asserts rst in DRAIN.
  task automatic run_op(input int base, input bit with_clear, input bit poke, input bit abort);
    longint sum;
    int     slot;
    sum = 0;
    for (int i = 0; i < VW; i++) begin
      sum += longint'(mem_a[(base + i) % DEPTH]) * longint'(mem_b[(base + i) % DEPTH]);
    end
    @(negedge clk);
    start         = 1'b1;
    clear_results = with_clear;
    base_addr     = AW'(base);
    if (with_clear) n_writes = 0;
    slot = n_writes % SLOTS;
    for (int k = 1; k <= VW + 4; k++) begin
      @(negedge clk);
      start         = 1'b0;
      clear_results = 1'b0;
      base_addr     = AW'($urandom);
      if (poke && k == 2) begin
        start         = 1'b1;
        clear_results = 1'b1;
      end
      if (k <= VW) begin
        check_eq("fetch_rd_en", mem_rd_en, 1);
        check_eq("fetch_addr", mem_rd_addr, (base + k - 1) % DEPTH);
        check_eq("fetch_busy", busy, 1);
        check_eq("fetch_stage", stage, 1);
        check_eq("fetch_wr_en", res_wr_en, 0);
      end else if (k == VW + 1) begin
        check_eq("drain_stage", stage, 2);
        check_eq("drain_rd_en", mem_rd_en, 0);
        check_eq("drain_busy", busy, 1);
        if (abort) begin
          rst = 1'b1;
          @(negedge clk);
          check_reset_values("abort");
          rst      = 1'b0;
          n_writes = 0;
          return;
        end
      end else if (k == VW + 2) begin
        check_eq("write_en", res_wr_en, 1);
        check_eq("write_addr", res_wr_addr, slot);
        check_eq("write_data", res_wr_data, sum % 256);
        check_eq("write_stage", stage, 3);
        check_eq("write_busy", busy, 1);
        n_writes++;
      end else if (k == VW + 3) begin
        check_eq("done_pulse", done, 1);
        check_eq("done_busy", busy, 0);
        check_eq("done_stage", stage, 4);
        check_eq("done_wr_en", res_wr_en, 0);
        check_eq("done_dot", dot_result, sum);
        check_eq("done_count", result_count, (n_writes > SLOTS) ? SLOTS : n_writes);
        check_eq("done_ovf", overflow, (n_writes > SLOTS) ? 1 : 0);
      end else begin
        check_eq("idle_done", done, 0);
        check_eq("idle_stage", stage, 0);
        check_eq("idle_busy", busy, 0);
      end
    end
  endtask

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    clear_results = 1'b0;
    base_addr     = '0;
    fill_random();
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      mem_a[i] = DW'(i + 1);
      mem_b[i] = 8'd1;
    end
    run_op(0, 1'b0, 1'b0, 1'b0);
    check_eq("op1_dot", dot_result, 10);
    check_eq("op1_count", result_count, 1);

    for (int i = 0; i < 4; i++) begin
      mem_a[4 + i] = DW'(2 * (i + 1));
      mem_b[4 + i] = DW'(i + 1);
    end
    run_op(4, 1'b0, 1'b0, 1'b0);
    check_eq("op2_dot", dot_result, 60);
    check_eq("op2_count", result_count, 2);

    for (int i = 0; i < 4; i++) begin
      mem_a[8 + i] = 8'd255;
      mem_b[8 + i] = 8'd255;
    end
    run_op(8, 1'b0, 1'b0, 1'b0);
    check_eq("op3_dot", dot_result, 260100);

    run_op(30, 1'b0, 1'b0, 1'b0);

    // Fill the result memory past its end: 17 writes after a clear
    fill_random();
    run_op($urandom_range(DEPTH - 1), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      run_op($urandom_range(DEPTH - 1), 1'b0, 1'b0, 1'b0);
    end
    check_eq("wrap_count", result_count, 16);
    check_eq("wrap_ovf", overflow, 1);

    @(negedge clk);
    clear_results = 1'b1;
    @(negedge clk);
    clear_results = 1'b0;
    n_writes      = 0;
    check_eq("clear_count", result_count, 0);
    check_eq("clear_ovf", overflow, 0);

    run_op($urandom_range(DEPTH - 1), 1'b0, 1'b1, 1'b0);
    check_eq("poke_count", result_count, 1);

    run_op($urandom_range(DEPTH - 1), 1'b0, 1'b0, 1'b1);
    run_op($urandom_range(DEPTH - 1), 1'b0, 1'b0, 1'b0);
    check_eq("post_abort_count", result_count, 1);

    for (int r = 0; r < 8; r++) begin
      fill_random();
      run_op($urandom_range(DEPTH - 1), 1'($urandom_range(1)), 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
